// File: rtl/mac_bus_sequencer_if.sv
// ---------------------------------------------------------------------------
// mac_bus_sequencer_if
// Bus bundle between the 68k side (CPU strobe, address decode, DMA requests)
// and the Mac bus sequencer.
//   master : CPU / decoder / DMA-engine view (drives strobes and requests)
//   slave  : sequencer view (drives phase, slot, grants, /DTACK, /BERR)
// ---------------------------------------------------------------------------
interface mac_bus_sequencer_if #(
   parameter int unsigned PHASES  = 8,
   parameter int unsigned NUM_DMA = 3
);
   localparam int unsigned PW = $clog2(PHASES);

   logic                cpu_as_n;
   logic                sel_ram;
   logic                sel_rom;
   logic                sel_vpa;
   logic [NUM_DMA-1:0]  dma_req;

   logic [PW-1:0]       bus_phase;
   logic                cpu_slot;
   logic [NUM_DMA-1:0]  dma_grant;
   logic                cpu_mem_grant;
   logic                cycle_ready;
   logic                cpu_dtack_n;
   logic                cpu_berr_n;

   modport master (
      output cpu_as_n, sel_ram, sel_rom, sel_vpa, dma_req,
      input  bus_phase, cpu_slot, dma_grant, cpu_mem_grant,
             cycle_ready, cpu_dtack_n, cpu_berr_n
   );

   modport slave (
      input  cpu_as_n, sel_ram, sel_rom, sel_vpa, dma_req,
      output bus_phase, cpu_slot, dma_grant, cpu_mem_grant,
             cycle_ready, cpu_dtack_n, cpu_berr_n
   );
endinterface

// File: rtl/mac_bus_sequencer.sv
// ---------------------------------------------------------------------------
// mac_bus_sequencer
// Owns the Mac bus-phase counter, alternates CPU and DMA slots, arbitrates the
// DMA channels (index 0 = highest priority), donates idle DMA slots to the CPU
// and generates the registered 68k /DTACK.
//
// Slot timing: bus_phase runs 0..PHASES-1; cpu_slot toggles on wrap and the
// slot after reset is a DMA slot.  DMA requests are sampled on the edge that
// opens a DMA slot, so dma_grant is already valid at phase 0 and stays put for
// the whole slot.  A DMA slot with no grant is donated to the CPU.
//
// Optional feature (macro BUS_TIMEOUT_EN): a watchdog counts unacknowledged
// /AS-low cycles and raises /BERR after TIMEOUT_CYC cycles.  Without the macro
// cpu_berr_n is tied high and TIMEOUT_CYC does not exist.
//
// PHASES must be a power of two >= 4; ACCEPT_PHASE < DONE_PHASE < PHASES-1.
// ---------------------------------------------------------------------------
module mac_bus_sequencer #(
   parameter int unsigned PHASES       = 8,
   parameter int unsigned NUM_DMA      = 3,
   parameter int unsigned ACCEPT_PHASE = 2,
   parameter int unsigned DONE_PHASE   = 4
`ifdef BUS_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC  = 1023
`endif
) (
   input  logic                 clk_sys,
   input  logic                 RESET,
   mac_bus_sequencer_if.slave   bus
);

   localparam int unsigned       PW       = $clog2(PHASES);
   localparam logic [PW-1:0]     LAST_PH  = PW'(PHASES - 1);
   localparam logic [PW-1:0]     ACC_PH   = PW'(ACCEPT_PHASE);
   localparam logic [PW-1:0]     DONE_PH  = PW'(DONE_PHASE);
   localparam logic [NUM_DMA-1:0] NO_GRANT = {NUM_DMA{1'b0}};

   // CPU access tracking: idle, or a RAM/ROM cycle accepted and not yet ended
   typedef enum logic [0:0] {
      ACC_IDLE = 1'b0,
      ACC_BUSY = 1'b1
   } acc_state_t;

   // Fixed-priority pick: one-hot of the lowest set request bit
   function automatic logic [NUM_DMA-1:0] lowest_one(input logic [NUM_DMA-1:0] req);
      logic [NUM_DMA-1:0] oh;
      oh = {NUM_DMA{1'b0}};
      for (int i = int'(NUM_DMA) - 1; i >= 0; i--) begin
         if (req[i]) begin
            oh    = {NUM_DMA{1'b0}};
            oh[i] = 1'b1;
         end
      end
      return oh;
   endfunction

   // registers
   logic [PW-1:0]       phase_r;
   logic                cpu_slot_r;
   logic [NUM_DMA-1:0]  dma_grant_r;
   logic                cpu_mem_grant_r;
   logic                cycle_ready_r;
   logic                dtack_n_r;
   acc_state_t          acc_state_r;

   // combinational
   logic [PW-1:0]       next_phase_s;
   logic                slot_end_s;
   logic                donated_s;
   logic                ram_slot_ok_s;
   logic                accept_ram_s;
   logic                accept_rom_s;
   logic                as_acc_s;
   logic                mem_ack_s;
   logic                io_ack_s;
   logic                hold_ack_s;
   logic                berr_n_s;
   acc_state_t          acc_state_nxt_s;

   assign next_phase_s  = phase_r + PW'(1);
   assign slot_end_s    = (phase_r == LAST_PH);
   assign donated_s     = ~cpu_slot_r & (dma_grant_r == NO_GRANT);
   assign ram_slot_ok_s = cpu_slot_r | donated_s;

   // Slot timing: free-running phase counter, CPU/DMA slot flips on wrap
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         phase_r    <= {PW{1'b0}};
         cpu_slot_r <= 1'b0;
      end else begin
         phase_r <= next_phase_s;
         if (slot_end_s) begin
            cpu_slot_r <= ~cpu_slot_r;
         end
      end
   end

   // Commit strobe: registered so it is high exactly while bus_phase is last
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         cycle_ready_r <= 1'b0;
      end else begin
         cycle_ready_r <= (next_phase_s == LAST_PH);
      end
   end

   // DMA arbitration: sample requests as a DMA slot opens, hold grant all slot
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         dma_grant_r <= NO_GRANT;
      end else if (slot_end_s) begin
         if (cpu_slot_r) begin
            dma_grant_r <= lowest_one(bus.dma_req);
         end else begin
            dma_grant_r <= NO_GRANT;
         end
      end
   end

   // CPU accept window: only at ACCEPT_PHASE, RAM also needs a usable slot
   always_comb begin
      accept_ram_s = 1'b0;
      accept_rom_s = 1'b0;
      if ((phase_r == ACC_PH) && !bus.cpu_as_n && (acc_state_r == ACC_IDLE)) begin
         if (bus.sel_ram) begin
            accept_ram_s = ram_slot_ok_s;
            accept_rom_s = 1'b0;
         end else begin
            accept_ram_s = 1'b0;
            accept_rom_s = bus.sel_rom;
         end
      end else begin
         accept_ram_s = 1'b0;
         accept_rom_s = 1'b0;
      end
   end

   // Access FSM state register
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         acc_state_r <= ACC_IDLE;
      end else begin
         acc_state_r <= acc_state_nxt_s;
      end
   end

   // Access FSM next state: leave BUSY only at slot end once /AS is released
   always_comb begin
      acc_state_nxt_s = acc_state_r;
      case (acc_state_r)
         ACC_IDLE: begin
            if (accept_ram_s || accept_rom_s) begin
               acc_state_nxt_s = ACC_BUSY;
            end else begin
               acc_state_nxt_s = ACC_IDLE;
            end
         end
         ACC_BUSY: begin
            if (slot_end_s && bus.cpu_as_n) begin
               acc_state_nxt_s = ACC_IDLE;
            end else begin
               acc_state_nxt_s = ACC_BUSY;
            end
         end
         default: acc_state_nxt_s = ACC_IDLE;
      endcase
   end

   // Access FSM outputs: accepted-cycle flag
   always_comb begin
      as_acc_s = 1'b0;
      case (acc_state_r)
         ACC_IDLE: as_acc_s = 1'b0;
         ACC_BUSY: as_acc_s = 1'b1;
         default:  as_acc_s = 1'b0;
      endcase
   end

   // RAM ownership: from the accepting phase to the end of the slot
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         cpu_mem_grant_r <= 1'b0;
      end else if (slot_end_s) begin
         cpu_mem_grant_r <= 1'b0;
      end else if (accept_ram_s) begin
         cpu_mem_grant_r <= 1'b1;
      end
   end

   // DTACK terms: memory data valid, unmapped I/O, or hold until /AS rises;
   // VPA-terminated accesses never see DTACK
   always_comb begin
      mem_ack_s  = 1'b0;
      io_ack_s   = 1'b0;
      hold_ack_s = 1'b0;
      if (!bus.cpu_as_n && !bus.sel_vpa) begin
         mem_ack_s  = as_acc_s && (bus.sel_rom || cpu_mem_grant_r) && (phase_r >= DONE_PH);
         io_ack_s   = !bus.sel_ram && !bus.sel_rom;
         hold_ack_s = !dtack_n_r;
      end else begin
         mem_ack_s  = 1'b0;
         io_ack_s   = 1'b0;
         hold_ack_s = 1'b0;
      end
   end

   // /DTACK register: one cycle behind its terms, released after /AS rises
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         dtack_n_r <= 1'b1;
      end else begin
         dtack_n_r <= ~(mem_ack_s | io_ack_s | hold_ack_s);
      end
   end

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned   TW     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYC);
   localparam logic [TW-1:0] TO_PRE = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] to_cnt_r;
   logic          berr_n_r;

   // Watchdog: count unacknowledged /AS-low cycles, raise /BERR at the limit
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         to_cnt_r <= {TW{1'b0}};
         berr_n_r <= 1'b1;
      end else if (bus.cpu_as_n) begin
         to_cnt_r <= {TW{1'b0}};
         berr_n_r <= 1'b1;
      end else if (dtack_n_r && !bus.sel_vpa && (to_cnt_r != TO_LIM)) begin
         to_cnt_r <= to_cnt_r + TW'(1);
         if (to_cnt_r == TO_PRE) begin
            berr_n_r <= 1'b0;
         end
      end
   end

   assign berr_n_s = berr_n_r;
`else
   assign berr_n_s = 1'b1;
`endif

   assign bus.bus_phase     = phase_r;
   assign bus.cpu_slot      = cpu_slot_r;
   assign bus.dma_grant     = dma_grant_r;
   assign bus.cpu_mem_grant = cpu_mem_grant_r;
   assign bus.cycle_ready   = cycle_ready_r;
   assign bus.cpu_dtack_n   = dtack_n_r;
   assign bus.cpu_berr_n    = berr_n_s;

endmodule
